// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction-memory burst engine:
// FSM state encoding, burst length helper and read-latency range check.
package inst_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int MIN_READ_LATENCY = 1;
   localparam int MAX_READ_LATENCY = 3;

   // Words per cache line for a given offset-field width.
   function automatic int burst_len(input int block_offset_width);
      return 1 << block_offset_width;
   endfunction

   // BRAM latencies the beat pipeline is built for.
   function automatic bit read_latency_ok(input int lat);
      return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
   endfunction

endpackage

// File: rtl/inst_burst_reader_lat_pipe.sv
// lat_pipe: DEPTH-stage shift register carrying {valid,last} alongside the
// BRAM read pipeline. Async clear on reset, synchronous flush on abort.
// busy reports that at least one beat is still in flight.
module lat_pipe #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic flush,
   input  logic in_valid,
   input  logic in_last,
   output logic out_valid,
   output logic out_last,
   output logic busy
);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] last_q;

   // Shift valid/last one stage per cycle; flush drops everything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         last_q  <= '0;
      end else if (flush) begin
         valid_q <= '0;
         last_q  <= '0;
      end else begin
         valid_q[0] <= in_valid;
         last_q[0]  <= in_last;
         for (int i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            last_q[i]  <= last_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_last  = last_q[DEPTH-1];
   assign busy      = |valid_q;

endmodule

// File: rtl/inst_burst_reader.sv
// inst_burst_reader: streams one cache line (BURST_LEN words) from a
// synchronous BRAM to the instruction cache for each miss request.
// Optional performance counters are enabled with macro INST_BURST_PERF_EN.
//
// Beat interface: mem_read is meaningful only in cycles where mem_read_valid
// is high; there is no back-pressure, every valid beat is consumed in the
// cycle it appears. mem_last accompanies the final beat of a line.
// The request side is level based: mem_req_op stays high for the whole miss,
// and dropping it during issue aborts the burst.
module inst_burst_reader
   import inst_mem_pkg::*;
#(
   parameter int DATA_WIDTH         = 32,
   parameter int ADDR_WIDTH         = 16,
   parameter int BLOCK_OFFSET_WIDTH = 5,
   parameter int READ_LATENCY       = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_req_op,
   output logic [DATA_WIDTH-1:0] mem_read,
   output logic                  mem_read_valid,
   output logic                  mem_last,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic                  bram_en,
   input  logic [DATA_WIDTH-1:0] bram_dout,
`ifdef INST_BURST_PERF_EN
   output logic [31:0]           perf_bursts,
   output logic [31:0]           perf_stall,
`endif
   output state_t                dbg_state
);

   localparam int BOW       = BLOCK_OFFSET_WIDTH;
   localparam int CW        = BOW + 1;
   localparam int BURST_LEN = burst_len(BOW);
   localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

   if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
      $error("inst_burst_reader: READ_LATENCY must be in 1..3");
   end

   state_t                 state;
   state_t                 state_nxt;
   logic [ADDR_WIDTH-BOW-1:0] line_q;
   logic [CW-1:0]          issue_cnt;
   logic                   seen_low;
   logic                   issue;
   logic                   abort;
   logic                   issue_last;
   logic                   pipe_busy;

   // Offset bits of the request are replaced by issue_cnt, never consumed.
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, mem_addr[BOW-1:0]};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus per-cycle issue/abort strobes.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      abort     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_req_op) begin
               state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (!mem_req_op) begin
               abort     = 1'b1;
               state_nxt = ST_IDLE;
            end else begin
               issue = 1'b1;
               if (issue_cnt == LAST_IDX) begin
                  state_nxt = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // The request may stay high one stale cycle after mem_last;
            // once it has been seen low we leave as soon as beats retire.
            if (!pipe_busy && (!mem_req_op || seen_low)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Line address capture, issue counter and request-dropped tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q    <= '0;
         issue_cnt <= '0;
         seen_low  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               issue_cnt <= '0;
               seen_low  <= 1'b0;
               if (mem_req_op) begin
                  line_q <= mem_addr[ADDR_WIDTH-1:BOW];
               end
            end
            ST_READ: begin
               if (issue) begin
                  issue_cnt <= issue_cnt + CW'(1);
               end
            end
            ST_DRAIN: begin
               if (!mem_req_op) begin
                  seen_low <= 1'b1;
               end
            end
            default: begin
               issue_cnt <= '0;
            end
         endcase
      end
   end

   assign issue_last = issue && (issue_cnt == LAST_IDX);
   assign bram_en    = issue;
   assign bram_addr  = issue ? {line_q, issue_cnt[BOW-1:0]} : '0;
   assign mem_read   = bram_dout;
   assign dbg_state  = state;

   lat_pipe #(
      .DEPTH(READ_LATENCY)
   ) u_lat_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (abort),
      .in_valid (issue),
      .in_last  (issue_last),
      .out_valid(mem_read_valid),
      .out_last (mem_last),
      .busy     (pipe_busy)
   );

`ifdef INST_BURST_PERF_EN
   // Saturating counters: completed lines and cycles spent busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_bursts <= '0;
         perf_stall  <= '0;
      end else begin
         if (mem_last && (perf_bursts != 32'hFFFF_FFFF)) begin
            perf_bursts <= perf_bursts + 32'd1;
         end
         if ((state != ST_IDLE) && (perf_stall != 32'hFFFF_FFFF)) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_inst_burst_reader.sv
// Bench for inst_burst_reader: three instances with READ_LATENCY 1, 2, 3,
// each attached to a BRAM model over a shared random memory image.
// Expected beats are computed from the line-fill rules: word k of the line
// is issued at cycle 1+k and returned at cycle 1+k+latency.
module tb_inst_burst_reader;
   import inst_mem_pkg::*;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int BOW = 5;
   localparam int BL  = 32;
   localparam int NI  = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   // Clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [AW-1:0] addr_a  [NI];
   logic          req_a   [NI];
   logic [DW-1:0] rd_a    [NI];
   logic          val_a   [NI];
   logic          last_a  [NI];
   logic [AW-1:0] baddr_a [NI];
   logic          en_a    [NI];
   logic [DW-1:0] dout_a  [NI];
   state_t        st_a    [NI];
`ifdef INST_BURST_PERF_EN
   logic [31:0]   pb_a    [NI];
   logic [31:0]   ps_a    [NI];
`endif

   logic [DW-1:0] bram_mem [0:65535];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int L = g + 1;
      logic [DW-1:0] dq [L];

      // BRAM model: data appears L cycles after the enabled read.
      always @(posedge clk) begin
         if (en_a[g]) dq[0] <= bram_mem[baddr_a[g]];
         for (int i = 1; i < L; i++) dq[i] <= dq[i-1];
      end
      assign dout_a[g] = dq[L-1];

      inst_burst_reader #(
         .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
         .BLOCK_OFFSET_WIDTH(BOW), .READ_LATENCY(L)
      ) u_dut (
         .clk(clk), .rst_n(rst_n),
         .mem_addr(addr_a[g]), .mem_req_op(req_a[g]),
         .mem_read(rd_a[g]), .mem_read_valid(val_a[g]), .mem_last(last_a[g]),
         .bram_addr(baddr_a[g]), .bram_en(en_a[g]), .bram_dout(dout_a[g]),
`ifdef INST_BURST_PERF_EN
         .perf_bursts(pb_a[g]), .perf_stall(ps_a[g]),
`endif
         .dbg_state(st_a[g])
      );
   end

   // Drive one request on instance li and check every cycle against the
   // line-fill model. abort_at / rst_at (cycle index, -1 = none) cut the
   // burst by dropping the request or pulsing reset.
   task automatic run_burst(input int li, input logic [AW-1:0] addr,
                            input int abort_at, input int rst_at,
                            output int first_beat, output int last_beat);
      int lat, cut, k;
      logic [AW-1:0] base, exp_a;
      logic exp_en, exp_v, exp_l;
      lat  = li + 1;
      base = {addr[AW-1:BOW], {BOW{1'b0}}};
      cut  = 1 << 30;
      if (abort_at >= 0) cut = abort_at;
      if (rst_at >= 0 && rst_at < cut) cut = rst_at;
      first_beat = -1;
      last_beat  = -1;
      for (int t = 0; t <= 33 + lat; t++) begin
         @(posedge clk); #1;
         if (t == rst_at) rst_n = 1'b0;
         if (rst_at >= 0 && t == rst_at + 2) rst_n = 1'b1;
         req_a[li]  = (t < 33 + lat) && (t < cut);
         addr_a[li] = addr;
         @(negedge clk);
         exp_en = (t >= 1) && (t <= BL) && (t < cut);
         exp_a  = exp_en ? base + AW'(t - 1) : '0;
         k      = t - 1 - lat;
         exp_v  = (k >= 0) && (k < BL) && (t < cut);
         exp_l  = exp_v && (k == BL - 1);
         checks++;
         if (en_a[li] !== exp_en) begin
            errors++;
            $display("FAIL bram_en lat=%0d t=%0d got %b expected %b", lat, t, en_a[li], exp_en);
         end
         checks++;
         if (baddr_a[li] !== exp_a) begin
            errors++;
            $display("FAIL bram_addr lat=%0d t=%0d got %h expected %h", lat, t, baddr_a[li], exp_a);
         end
         if (t != abort_at) begin
            checks++;
            if (val_a[li] !== exp_v) begin
               errors++;
               $display("FAIL valid lat=%0d t=%0d got %b expected %b", lat, t, val_a[li], exp_v);
            end
            checks++;
            if (last_a[li] !== exp_l) begin
               errors++;
               $display("FAIL last lat=%0d t=%0d got %b expected %b", lat, t, last_a[li], exp_l);
            end
         end
         if (exp_v) begin
            checks++;
            if (rd_a[li] !== bram_mem[base + AW'(k)]) begin
               errors++;
               $display("FAIL data lat=%0d word=%0d got %h expected %h", lat, k, rd_a[li], bram_mem[base + AW'(k)]);
            end
            if (k == 0) first_beat = cyc;
            if (exp_l) last_beat = cyc;
         end
      end
   endtask

   // Idle cycles with the request low: no reads and no beats expected.
   task automatic idle_cycles(input int li, input int n);
      for (int t = 0; t < n; t++) begin
         @(posedge clk); #1;
         req_a[li] = 1'b0;
         @(negedge clk);
         checks++;
         if (en_a[li] !== 1'b0 || val_a[li] !== 1'b0 || last_a[li] !== 1'b0) begin
            errors++;
            $display("FAIL idle lat=%0d got en=%b valid=%b last=%b expected 0", li + 1, en_a[li], val_a[li], last_a[li]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (en_a[i] !== 1'b0 || baddr_a[i] !== '0 || val_a[i] !== 1'b0 ||
             last_a[i] !== 1'b0 || st_a[i] !== ST_IDLE) begin
            errors++;
            $display("FAIL reset inst=%0d got en=%b addr=%h valid=%b last=%b state=%0d expected all 0",
                     i, en_a[i], baddr_a[i], val_a[i], last_a[i], st_a[i]);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_lat1();
      int f, l;
      run_burst(0, 16'h0123, -1, -1, f, l);
   endtask

   task automatic test_lat2();
      int f, l;
      run_burst(1, 16'h0123, -1, -1, f, l);
   endtask

   task automatic test_back_to_back();
      int f1, l1, f2, l2;
      for (int li = 0; li < NI; li++) begin
         run_burst(li, 16'($urandom_range(0, 65535)), -1, -1, f1, l1);
         run_burst(li, 16'h0200, -1, -1, f2, l2);
         checks++;
         if (f2 - l1 - 1 != 2 + li + 1) begin
            errors++;
            $display("FAIL b2b_gap lat=%0d got %0d expected %0d", li + 1, f2 - l1 - 1, 2 + li + 1);
         end
         idle_cycles(li, 4);
      end
   endtask

   task automatic test_abort();
      int f, l;
      for (int li = 0; li < NI; li++) begin
         run_burst(li, 16'h0040, 1 + 10 + li + 1, -1, f, l);
         run_burst(li, 16'($urandom_range(0, 65535)), -1, -1, f, l);
      end
   endtask

   task automatic test_reset_mid();
      int f, l;
      for (int li = 0; li < NI; li++) begin
         run_burst(li, 16'($urandom_range(0, 65535)), -1, 1 + 20 + li + 1, f, l);
         idle_cycles(li, 3);
         run_burst(li, 16'($urandom_range(0, 65535)), -1, -1, f, l);
      end
   endtask

   task automatic test_random();
      int f, l, li, ab;
      for (int n = 0; n < 9; n++) begin
         li = $urandom_range(0, NI - 1);
         ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, BL) : -1;
         run_burst(li, 16'($urandom_range(0, 65535)), ab, -1, f, l);
         idle_cycles(li, $urandom_range(0, 3));
      end
   endtask

`ifdef INST_BURST_PERF_EN
   task automatic test_perf();
      int f, l;
      test_reset();
      for (int n = 0; n < 3; n++) begin
         run_burst(0, 16'($urandom_range(0, 65535)), -1, -1, f, l);
      end
      @(negedge clk);
      checks++;
      if (pb_a[0] !== 32'd3) begin
         errors++;
         $display("FAIL perf_bursts got %0d expected 3", pb_a[0]);
      end
      checks++;
      if (ps_a[0] !== 32'(3 * (BL + 1 + 1))) begin
         errors++;
         $display("FAIL perf_stall got %0d expected %0d", ps_a[0], 3 * (BL + 1 + 1));
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < NI; i++) begin
         req_a[i]  = 1'b0;
         addr_a[i] = '0;
      end
      for (int a = 0; a < 65536; a++) bram_mem[a] = $urandom;
      test_reset();
      test_lat1();
      test_lat2();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_random();
`ifdef INST_BURST_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
